// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 master.
//   state_e   : master FSM states
//   ADDR_W    : default address bits per frame
//   DATA_W    : default data bits per frame
//   FRAME_LEN : total bits per frame (address + RW + data)
//   RW_READ / RW_WRITE : encoding of the RW frame bit
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_e;

    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 8;
    localparam int FRAME_LEN = ADDR_W + 1 + DATA_W;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator for the SPI master.
// Divides clk so that each SCLK half-period lasts CLK_DIV system clocks and
// emits single-cycle strobes on the system-clock edge where SCLK rises/falls.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   en_i       : run the divider (held cleared, SCLK low, when 0)
//   rise_o     : high in the cycle whose closing edge raises SCLK
//   fall_o     : high in the cycle whose closing edge lowers SCLK
//   sclk_o     : registered SPI clock, idles low
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic rise_o,
    output logic fall_o,
    output logic sclk_o
);

    localparam int CNT_W = $clog2(2 * CLK_DIV);
    localparam logic [CNT_W-1:0] RISE_AT = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] FALL_AT = CNT_W'(2 * CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;

    assign rise_o = en_i && (cnt_q == RISE_AT);
    assign fall_o = en_i && (cnt_q == FALL_AT);
    assign sclk_o = sclk_q;

    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (fall_o) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (rise_o) begin
                sclk_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one frame {addr, rw, data} per accepted start, MSB first.
// Ports:
//   clk, rst_n          : system clock, asynchronous active-low reset
//   start, rw, addr,
//   wdata               : request; fields captured when start is accepted in IDLE
//   busy                : high from the cycle after accept until the done cycle
//   done                : one-cycle pulse at transaction end
//   rdata               : last read result, updated only when a read completes
//   sclk, cs, mosi      : registered SPI pins (sclk idles low, cs idles high)
//   miso                : slave data, sampled raw at each internal SCLK rise
module spi_master #(
    parameter int CLK_DIV = 4,
    parameter int ADDR_W  = spi_pkg::ADDR_W,
    parameter int DATA_W  = spi_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              sclk,
    output logic              cs,
    output logic              mosi,
    input  logic              miso
);

    import spi_pkg::*;

    localparam int FRAME_BITS = ADDR_W + 1 + DATA_W;
    localparam int HCNT_W     = $clog2(2 * FRAME_BITS);
    localparam int WAIT_W     = $clog2(2 * CLK_DIV);

    localparam logic [WAIT_W-1:0] HALF_LAST = WAIT_W'(CLK_DIV - 1);
    localparam logic [WAIT_W-1:0] GAP_LAST  = WAIT_W'(2 * CLK_DIV - 1);
    localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(2 * FRAME_BITS - 1);
    // First half-period index (counted from 0) that is a data-phase rise.
    localparam logic [HCNT_W-1:0] DATA_HCNT = HCNT_W'(2 * (ADDR_W + 1));

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic [DATA_W-1:0]   cap_q, cap_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rw_q, rw_d;
    logic                cs_q, cs_d;
    logic                mosi_q, mosi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                sclk_rise, sclk_fall;
    logic [DATA_W-1:0]   wfill;

    // Reads load zeros into the data field so MOSI is low in the data phase.
    assign wfill = (rw == RW_READ) ? '0 : wdata;

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (state_q == SHIFT),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall),
        .sclk_o (sclk)
    );

    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign cs    = cs_q;
    assign mosi  = mosi_q;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        hcnt_d  = hcnt_q;
        sr_d    = sr_q;
        cap_d   = cap_q;
        rdata_d = rdata_q;
        rw_d    = rw_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = {addr, rw, wfill};
                    rw_d    = rw;
                    busy_d  = 1'b1;
                    cs_d    = 1'b0;
                    mosi_d  = addr[ADDR_W-1];
                    wait_d  = '0;
                    state_d = SETUP;
                end
            end

            SETUP: begin
                if (wait_q == HALF_LAST) begin
                    wait_d  = '0;
                    hcnt_d  = '0;
                    state_d = SHIFT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            SHIFT: begin
                // hcnt_q counts completed SCLK toggles; even values precede a rise.
                if (sclk_rise) begin
                    hcnt_d = hcnt_q + 1'b1;
                    if (rw_q == RW_READ && hcnt_q >= DATA_HCNT) begin
                        cap_d = {cap_q[DATA_W-2:0], miso};
                    end
                end
                if (sclk_fall) begin
                    if (hcnt_q == HCNT_LAST) begin
                        hcnt_d  = '0;
                        wait_d  = '0;
                        state_d = HOLD;
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                        sr_d   = {sr_q[FRAME_BITS-2:0], 1'b0};
                        mosi_d = sr_q[FRAME_BITS-2];
                    end
                end
            end

            HOLD: begin
                if (wait_q == HALF_LAST) begin
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    wait_d  = '0;
                    state_d = GAP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            GAP: begin
                if (wait_q == GAP_LAST) begin
                    wait_d  = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                    if (rw_q == RW_READ) begin
                        rdata_d = cap_q;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wait_q  <= '0;
            hcnt_q  <= '0;
            sr_q    <= '0;
            cap_q   <= '0;
            rdata_q <= '0;
            rw_q    <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            hcnt_q  <= hcnt_d;
            sr_q    <= sr_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
            rw_q    <= rw_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;

    localparam int CD  = 4;
    localparam int CD2 = 2;

    logic       clk;
    logic       rst_n;

    logic       start, rw, miso;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy, done, sclk, cs, mosi;
    logic [7:0] rdata;

    logic       start2, rw2, miso2;
    logic [6:0] addr2;
    logic [7:0] wdata2;
    logic       busy2, done2, sclk2, cs2, mosi2;
    logic [7:0] rdata2;

    int vectors;
    int miscompares;
    logic [7:0] rdata_m;

    spi_master #(.CLK_DIV(CD), .ADDR_W(7), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso)
    );

    spi_master #(.CLK_DIV(CD2), .ADDR_W(7), .DATA_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .rw(rw2), .addr(addr2),
        .wdata(wdata2), .busy(busy2), .done(done2), .rdata(rdata2),
        .sclk(sclk2), .cs(cs2), .mosi(mosi2), .miso(miso2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request on dut and watches the pins for a fixed window,
    // acting as the slave (MISO changes after falling SCLK edges 8..15).
    task automatic run_frame(
        input  logic [6:0] a, input logic r, input logic [7:0] wd,
        input  logic [7:0] sbyte, input bit stuck, input int inj_n,
        output logic [15:0] bits, output int rises, output int cslow,
        output int done_n, output int done_cnt,
        output logic busy0, output logic busy_done, output logic [7:0] rd_done);
        int   falls;
        logic prev;
        addr  = a; rw = r; wdata = wd;
        miso  = stuck ? 1'b1 : 1'($urandom);
        start = 1'b1;
        bits = '0; rises = 0; falls = 0; cslow = 0; done_n = -1; done_cnt = 0;
        busy0 = 1'b0; busy_done = 1'b1; rd_done = '0; prev = 1'b0;
        for (int n = 0; n < 36 * CD + 6; n++) begin
            @(posedge clk); #1;
            if (n == 0) begin
                start = 1'b0;
                busy0 = busy;
            end
            if (n == inj_n) begin
                start = 1'b1; addr = 7'h11; rw = ~r; wdata = ~wd;
            end else if (n == inj_n + 1) begin
                start = 1'b0;
            end
            if (sclk && !prev) begin
                bits = {bits[14:0], mosi};
                rises++;
            end
            if (!sclk && prev) begin
                falls++;
                if (!stuck) begin
                    if (falls >= 8 && falls <= 15) miso = sbyte[15 - falls];
                    else                           miso = 1'($urandom);
                end
            end
            prev = sclk;
            if (!cs) cslow++;
            if (done) begin
                done_cnt++;
                if (done_n < 0) begin
                    done_n = n; busy_done = busy; rd_done = rdata;
                end
            end
        end
    endtask

    task automatic test_reset();
        vectors++; if (cs !== 1'b1)    begin miscompares++; $display("FAIL reset_cs got %b want 1", cs); end
        vectors++; if (sclk !== 1'b0)  begin miscompares++; $display("FAIL reset_sclk got %b want 0", sclk); end
        vectors++; if (mosi !== 1'b0)  begin miscompares++; $display("FAIL reset_mosi got %b want 0", mosi); end
        vectors++; if (busy !== 1'b0)  begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0)  begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
        vectors++; if (rdata !== 8'h00) begin miscompares++; $display("FAIL reset_rdata got %h want 00", rdata); end
        vectors++; if (cs2 !== 1'b1 || sclk2 !== 1'b0) begin
            miscompares++; $display("FAIL reset_dut2_pins got cs=%b sclk=%b want cs=1 sclk=0", cs2, sclk2);
        end
    endtask

    // Fixed cases from the plan, boundary patterns, then random requests.
    task automatic test_frames();
        logic [6:0]  a;
        logic        r;
        logic [7:0]  wd, sb;
        bit          stuck;
        logic [15:0] bits, exp;
        int          rises, cslow, done_n, done_cnt;
        logic        b0, bd;
        logic [7:0]  rd;
        for (int i = 0; i < 10; i++) begin
            stuck = 1'b0;
            a = 7'($urandom); r = 1'($urandom); wd = 8'($urandom); sb = 8'($urandom);
            case (i)
                0: begin a = 7'h2A; r = 1'b0; wd = 8'hC3; end
                1: begin a = 7'h05; r = 1'b1; sb = 8'h96; end
                2: begin a = 7'h00; r = 1'b0; wd = 8'h00; end
                3: begin r = 1'b1; stuck = 1'b1; end
                default: ;
            endcase
            exp = {a, r, (r ? 8'h00 : wd)};
            if (r) rdata_m = stuck ? 8'hFF : sb;
            run_frame(a, r, wd, sb, stuck, -1, bits, rises, cslow, done_n, done_cnt, b0, bd, rd);
            vectors++; if (bits !== exp) begin miscompares++; $display("FAIL frame%0d_mosi got %h want %h", i, bits, exp); end
            vectors++; if (rises !== 16) begin miscompares++; $display("FAIL frame%0d_rises got %0d want 16", i, rises); end
            vectors++; if (cslow !== 34 * CD) begin miscompares++; $display("FAIL frame%0d_cs_low got %0d want %0d", i, cslow, 34 * CD); end
            vectors++; if (done_n !== 36 * CD) begin miscompares++; $display("FAIL frame%0d_done_at got %0d want %0d", i, done_n, 36 * CD); end
            vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL frame%0d_done_count got %0d want 1", i, done_cnt); end
            vectors++; if (b0 !== 1'b1 || bd !== 1'b0) begin miscompares++; $display("FAIL frame%0d_busy got start=%b done=%b want 1/0", i, b0, bd); end
            vectors++; if (rd !== rdata_m) begin miscompares++; $display("FAIL frame%0d_rdata got %h want %h", i, rd, rdata_m); end
        end
    endtask

    task automatic test_busy_reject();
        logic [15:0] bits;
        int          rises, cslow, done_n, done_cnt;
        logic        b0, bd;
        logic [7:0]  rd;
        run_frame(7'h2A, 1'b0, 8'hC3, 8'h00, 1'b0, 20, bits, rises, cslow, done_n, done_cnt, b0, bd, rd);
        vectors++; if (bits !== 16'h54C3) begin miscompares++; $display("FAIL busy_mosi got %h want 54c3", bits); end
        vectors++; if (rises !== 16) begin miscompares++; $display("FAIL busy_rises got %0d want 16", rises); end
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL busy_done_count got %0d want 1", done_cnt); end
        vectors++; if (done_n !== 36 * CD) begin miscompares++; $display("FAIL busy_done_at got %0d want %0d", done_n, 36 * CD); end
        vectors++; if (rd !== rdata_m) begin miscompares++; $display("FAIL busy_rdata got %h want %h", rd, rdata_m); end
    endtask

    task automatic test_reset_mid();
        int          nr;
        logic        prev;
        logic [15:0] bits;
        int          rises, cslow, done_n, done_cnt;
        logic        b0, bd;
        logic [7:0]  rd;
        addr = 7'h33; rw = 1'b0; wdata = 8'h5A; start = 1'b1;
        nr = 0; prev = 1'b0;
        for (int n = 0; n < 300 && nr < 5; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (sclk && !prev) nr++;
            prev = sclk;
        end
        vectors++; if (nr !== 5) begin miscompares++; $display("FAIL midreset_reach_rise5 got %0d want 5", nr); end
        rst_n = 1'b0;
        #1;
        vectors++; if (cs !== 1'b1) begin miscompares++; $display("FAIL midreset_cs got %b want 1", cs); end
        vectors++; if (sclk !== 1'b0) begin miscompares++; $display("FAIL midreset_sclk got %b want 0", sclk); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy got %b want 0", busy); end
        vectors++; if (rdata !== 8'h00) begin miscompares++; $display("FAIL midreset_rdata got %h want 00", rdata); end
        rdata_m = 8'h00;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(7'h7F, 1'b0, 8'hFF, 8'h00, 1'b0, -1, bits, rises, cslow, done_n, done_cnt, b0, bd, rd);
        vectors++; if (bits !== 16'hFEFF) begin miscompares++; $display("FAIL postreset_mosi got %h want feff", bits); end
        vectors++; if (done_n !== 36 * CD) begin miscompares++; $display("FAIL postreset_done_at got %0d want %0d", done_n, 36 * CD); end
        vectors++; if (cslow !== 34 * CD) begin miscompares++; $display("FAIL postreset_cs_low got %0d want %0d", cslow, 34 * CD); end
        vectors++; if (rd !== 8'h00) begin miscompares++; $display("FAIL postreset_rdata got %h want 00", rd); end
    endtask

    // start held high on the CLK_DIV=2 instance; fields change at each done.
    task automatic test_back_to_back();
        logic [15:0] q[$];
        logic [15:0] bits, exp;
        logic [6:0]  a;
        logic [7:0]  d;
        logic        prev;
        int          nb, last, frames, hi;
        nb = 0; last = -1; frames = 0; hi = 0; prev = 1'b0; bits = '0;
        a = 7'($urandom); d = 8'($urandom);
        addr2 = a; wdata2 = d; rw2 = 1'b0; q.push_back({a, 1'b0, d});
        start2 = 1'b1;
        for (int cyc = 0; cyc < 4 * (36 * CD2 + 1) + 20 && frames < 3; cyc++) begin
            @(posedge clk); #1;
            if (sclk2 && !prev) begin
                bits = {bits[14:0], mosi2};
                nb++;
            end
            prev = sclk2;
            if (cs2) begin
                hi++;
            end else begin
                if (frames > 0 && hi > 0) begin
                    vectors++;
                    if (hi !== 2 * CD2 + 1) begin miscompares++; $display("FAIL b2b_cs_high got %0d want %0d", hi, 2 * CD2 + 1); end
                end
                hi = 0;
            end
            if (done2) begin
                exp = q.pop_front();
                vectors++; if (bits !== exp) begin miscompares++; $display("FAIL b2b%0d_mosi got %h want %h", frames, bits, exp); end
                vectors++; if (nb !== 16) begin miscompares++; $display("FAIL b2b%0d_rises got %0d want 16", frames, nb); end
                if (last >= 0) begin
                    vectors++;
                    if (cyc - last !== 36 * CD2 + 1) begin miscompares++; $display("FAIL b2b%0d_period got %0d want %0d", frames, cyc - last, 36 * CD2 + 1); end
                end
                last = cyc; nb = 0; frames++;
                if (frames == 3) begin
                    start2 = 1'b0;
                end else begin
                    a = 7'($urandom); d = 8'($urandom);
                    addr2 = a; wdata2 = d; q.push_back({a, 1'b0, d});
                end
            end
        end
        start2 = 1'b0;
        vectors++; if (frames !== 3) begin miscompares++; $display("FAIL b2b_frames got %0d want 3", frames); end
    endtask

    initial begin
        vectors = 0; miscompares = 0; rdata_m = 8'h00;
        rst_n = 1'b0;
        start = 1'b0; rw = 1'b0; addr = '0; wdata = '0; miso = 1'b0;
        start2 = 1'b0; rw2 = 1'b0; addr2 = '0; wdata2 = '0; miso2 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_frames();
        test_busy_reject();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
